// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture stage: default geometry, RGB444
// field layout, capture state encoding and the colour-bar palette.
package cam_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int LINE_SLOTS_DEF = 3;

  localparam int CH_W  = 4;
  localparam int PIX_W = 3 * CH_W;
  localparam int R_OFS = 2 * CH_W;
  localparam int G_OFS = CH_W;
  localparam int B_OFS = 0;

  localparam int X_W   = 10;
  localparam int Y_W   = 2;
  localparam int ROW_W = 9;

  typedef enum logic [1:0] {
    SYNC_WAIT  = 2'd0,
    FRAME_WAIT = 2'd1,
    LINE_GAP   = 2'd2,
    LINE       = 2'd3
  } cap_state_e;

  localparam logic [PIX_W-1:0] BAR_WHITE   = 12'hFFF;
  localparam logic [PIX_W-1:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [PIX_W-1:0] BAR_CYAN    = 12'h0FF;
  localparam logic [PIX_W-1:0] BAR_GREEN   = 12'h0F0;
  localparam logic [PIX_W-1:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [PIX_W-1:0] BAR_RED     = 12'hF00;
  localparam logic [PIX_W-1:0] BAR_BLUE    = 12'h00F;
  localparam logic [PIX_W-1:0] BAR_BLACK   = 12'h000;

  function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] bar);
    logic [PIX_W-1:0] c;
    case (bar)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Signal bundle between the OV7670 byte stream, the capture stage and its
// consumers (blur stage pixel port, display controller frame status).
interface camera_capture_if;
  import cam_pkg::*;

  // No backpressure: pixelValid, frameDone and frameErr are single-cycle
  // strobes and the sink must accept them in the cycle they are high.
  logic             vsync;
  logic             href;
  logic [7:0]       camData;
  logic [PIX_W-1:0] pixelOut;
  logic [X_W-1:0]   outX;
  logic [Y_W-1:0]   outY;
  logic [ROW_W-1:0] outRow;
  logic             pixelValid;
  logic             frameDone;
  logic             frameErr;
  cap_state_e       state;

  modport slave (
    input  vsync, href, camData,
    output pixelOut, outX, outY, outRow, pixelValid, frameDone, frameErr, state
  );

  modport master (
    output vsync, href, camData,
    input  pixelOut, outX, outY, outRow, pixelValid, frameDone, frameErr, state
  );
endinterface

// File: rtl/camera_capture_test_pattern_gen.sv
// Combinational colour-bar source: eight vertical bars selected by column[9:7].
module test_pattern_gen
  import cam_pkg::*;
(
  input  logic [X_W-1:0]   x_i,
  output logic [PIX_W-1:0] colour_o
);
  assign colour_o = bar_colour(x_i[X_W-1:X_W-3]);
endmodule

// File: rtl/camera_capture.sv
// OV7670 RGB444 byte-stream capture: pixels with column, line slot and row.
// Define CAPTURE_TEST_PATTERN_EN to replace camera pixels with colour bars.
module camera_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int LINE_SLOTS = LINE_SLOTS_DEF
) (
  input  logic             writeClk,
  input  logic             rstN,
  camera_capture_if.slave  bus
);

  localparam logic [X_W-1:0]   H_LIM     = X_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] V_LIM     = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W:0]   LINES_OK  = (ROW_W+1)'(V_ACTIVE);
  localparam logic [ROW_W:0]   LINES_SAT = (ROW_W+1)'(V_ACTIVE + 1);
  localparam logic [Y_W-1:0]   SLOT_LAST = Y_W'(LINE_SLOTS - 1);

  cap_state_e       state_q, state_d;
  logic             phase_q, phase_d;
  logic [CH_W-1:0]  hi_q, hi_d;
  logic [X_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [Y_W-1:0]   slot_q, slot_d;
  logic [ROW_W:0]   lines_q, lines_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [PIX_W-1:0] pix_src;

`ifdef CAPTURE_TEST_PATTERN_EN
  test_pattern_gen u_tpg (
    .x_i      (col_q),
    .colour_o (pix_src)
  );
`else
  assign pix_src = {hi_q, bus.camData};
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    col_d   = col_q;
    row_d   = row_q;
    slot_d  = slot_q;
    lines_d = lines_q;
    pix_d   = pix_q;
    x_d     = x_q;
    y_d     = y_q;
    orow_d  = orow_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      SYNC_WAIT: begin
        if (bus.vsync) state_d = FRAME_WAIT;
      end
      FRAME_WAIT: begin
        if (!bus.vsync) begin
          state_d = LINE_GAP;
          row_d   = '0;
          slot_d  = '0;
          lines_d = '0;
          phase_d = 1'b0;
          col_d   = '0;
        end
      end
      LINE_GAP: begin
        if (bus.vsync) begin
          state_d = FRAME_WAIT;
          done_d  = (lines_q == LINES_OK);
          err_d   = (lines_q != LINES_OK);
        end else if (bus.href) begin
          state_d = LINE;
          hi_d    = bus.camData[CH_W-1:0];
          phase_d = 1'b1;
        end
      end
      LINE: begin
        if (bus.vsync) begin
          // Abort: the partial line is discarded and the frame is flagged bad.
          state_d = FRAME_WAIT;
          err_d   = 1'b1;
          phase_d = 1'b0;
          col_d   = '0;
        end else if (!bus.href) begin
          state_d = LINE_GAP;
          phase_d = 1'b0;
          col_d   = '0;
          if (col_q != '0) begin
            if (lines_q != LINES_SAT) lines_d = lines_q + 1'b1;
            // col > 0 with row in range means this line emitted pixels.
            if (row_q < V_LIM) begin
              row_d  = row_q + 1'b1;
              slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end
          end
        end else if (!phase_q) begin
          hi_d    = bus.camData[CH_W-1:0];
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q < H_LIM) begin
            col_d = col_q + 1'b1;
            if (row_q < V_LIM) begin
              valid_d = 1'b1;
              pix_d   = pix_src;
              x_d     = col_q;
              y_d     = slot_q;
              orow_d  = row_q;
            end
          end
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge writeClk) begin
    if (!rstN) begin
      state_q <= SYNC_WAIT;
      phase_q <= 1'b0;
      hi_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      slot_q  <= '0;
      lines_q <= '0;
      pix_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      orow_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      col_q   <= col_d;
      row_q   <= row_d;
      slot_q  <= slot_d;
      lines_q <= lines_d;
      pix_q   <= pix_d;
      x_q     <= x_d;
      y_q     <= y_d;
      orow_q  <= orow_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.pixelOut   = pix_q;
  assign bus.outX       = x_q;
  assign bus.outY       = y_q;
  assign bus.outRow     = orow_q;
  assign bus.pixelValid = valid_q;
  assign bus.frameDone  = done_q;
  assign bus.frameErr   = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture on a reduced 8x4 geometry with 3 line slots.
module tb_camera_capture;
  import cam_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
  localparam int S = 3;
  localparam int W = 33;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [W-1:0] exp_q[$];
  int   n_done_exp = 0, n_err_exp = 0, n_done_seen = 0, n_err_seen = 0;

  // Bench-side reference state
  bit         m_armed = 0, m_seen_v = 0, m_phase = 0;
  logic [3:0] m_hi = '0;
  int         m_col = 0, m_row = 0, m_slot = 0, m_lines = 0;

  camera_capture_if bus ();

  camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_SLOTS(S)) dut (
    .writeClk (clk),
    .rstN     (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input int col, input logic [3:0] hi, input logic [7:0] d);
`ifdef CAPTURE_TEST_PATTERN_EN
    logic [9:0] x;
    x = 10'(col);
    case (x[9:7])
      3'd0: return 12'hFFF;
      3'd1: return 12'hFF0;
      3'd2: return 12'h0FF;
      3'd3: return 12'h0F0;
      3'd4: return 12'hF0F;
      3'd5: return 12'hF00;
      3'd6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return {hi, d};
`endif
  endfunction

  // Scoreboard: every strobe pops one expected {pixel, x, y, row}.
  always @(negedge clk) begin
    if (bus.pixelValid) begin
      if (exp_q.size() == 0) check("unexpected_pixel", 40'd1, 40'd0);
      else check("pixel", 40'({bus.pixelOut, bus.outX, bus.outY, bus.outRow}), 40'(exp_q.pop_front()));
      if (bus.frameDone || bus.frameErr) check("pulse_overlap", 40'd1, 40'd0);
    end
    if (bus.frameDone) n_done_seen++;
    if (bus.frameErr) n_err_seen++;
  end

  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    bus.vsync = v;
    bus.href = h;
    bus.camData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    if (!m_phase) begin
      m_hi = d[3:0];
      m_phase = 1;
    end else begin
      if (m_armed && m_col < H && m_row < V)
        exp_q.push_back({exp_pix(m_col, m_hi, d), 10'(m_col), 2'(m_slot), 9'(m_row)});
      m_col++;
      m_phase = 0;
    end
    tick(1'b0, 1'b1, d);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic end_line();
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    if (m_armed && m_col > 0) begin
      if (m_lines < V + 1) m_lines++;
      if (m_row < V) begin
        m_row++;
        m_slot = (m_slot == S - 1) ? 0 : m_slot + 1;
      end
    end
    m_col = 0;
    m_phase = 0;
  endtask

  task automatic vsync_rise();
    logic [1:0] ev;
    ev = 2'b00;
    if (m_armed) ev = (m_lines == V) ? 2'b10 : 2'b01;
    n_done_exp += int'(ev[1]);
    n_err_exp += int'(ev[0]);
    tick(1'b1, 1'b0, 8'h00);
    check("frame_pulse", 40'({bus.frameDone, bus.frameErr}), 40'(ev));
    tick(1'b1, 1'b0, 8'h00);
    check("frame_pulse_len", 40'({bus.frameDone, bus.frameErr}), 40'd0);
    m_armed = 0;
    m_seen_v = 1;
  endtask

  task automatic vsync_fall();
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    if (m_seen_v) begin
      m_armed = 1;
      m_row = 0;
      m_slot = 0;
      m_lines = 0;
    end
  endtask

  task automatic full_lines(input int n);
    for (int i = 0; i < n; i++) begin
      send_rand(2 * H);
      end_line();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix"}, 40'(bus.pixelOut), 40'd0);
    check({tag, "_xy"}, 40'({bus.outX, bus.outY, bus.outRow}), 40'd0);
    check({tag, "_strobes"}, 40'({bus.pixelValid, bus.frameDone, bus.frameErr}), 40'd0);
    check({tag, "_state"}, 40'(bus.state), 40'(SYNC_WAIT));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.vsync = 1'b0;
    bus.href = 1'b0;
    bus.camData = 8'h00;
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Bytes before the first vsync are ignored.
    send_rand(4);
    end_line();
    vsync_rise();
    vsync_fall();
    check("state_after_vsync", 40'(bus.state), 40'(LINE_GAP));

    // Frame A: directed first line, then three full lines -> frameDone.
    send_byte(8'h0A);
    send_byte(8'hBC);
    send_byte(8'h05);
    send_byte(8'h67);
    end_line();
    check("hold_after_line", 40'({bus.pixelOut, bus.outX, bus.outRow}), 40'({12'h567, 10'd1, 9'd0}));
    full_lines(3);
    check("hold_last_x", 40'({bus.outX, bus.outY, bus.outRow}), 40'({10'(H - 1), 2'd0, 9'(V - 1)}));
    vsync_rise();

    // Frame B: over-long line, odd-byte line, slot wrap -> frameDone.
    vsync_fall();
    send_rand(2 * H + 3);
    end_line();
    send_rand(3);
    end_line();
    full_lines(2);
    vsync_rise();

    // Frame C: one line too many; Frame D: too few.
    vsync_fall();
    full_lines(V + 1);
    vsync_rise();
    vsync_fall();
    full_lines(2);
    vsync_rise();

    // Frame E: vsync rises in the middle of a line.
    vsync_fall();
    full_lines(2);
    send_rand(7);
    n_err_exp++;
    tick(1'b1, 1'b1, 8'h5A);
    check("abort_pulse", 40'({bus.frameDone, bus.frameErr}), 40'b01);
    m_armed = 0;
    m_phase = 0;
    m_col = 0;
    tick(1'b1, 1'b0, 8'h00);
    check("abort_pulse_len", 40'({bus.frameDone, bus.frameErr}), 40'd0);

    // Frame F: reset mid-line, partial frame ignored, then a good frame.
    vsync_fall();
    full_lines(1);
    send_rand(5);
    rst_n = 1'b0;
    tick(1'b0, 1'b1, 8'h33);
    rst_n = 1'b1;
    m_armed = 0;
    m_seen_v = 0;
    m_phase = 0;
    m_col = 0;
    check_outputs_zero("midline_reset");
    send_rand(6);
    end_line();
    full_lines(1);
    vsync_rise();
    vsync_fall();
    full_lines(V);
    vsync_rise();

    repeat (3) tick(1'b0, 1'b0, 8'h00);
    check("scoreboard_drain", 40'(exp_q.size()), 40'd0);
    check("done_count", 40'(n_done_seen), 40'(n_done_exp));
    check("err_count", 40'(n_err_seen), 40'(n_err_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
